// File: rtl/idr_fu_pkg.sv
// Shared widths, op encoding and FSM state type for the integer divide/remainder unit.
package idr_fu_pkg;

  localparam int RSZ   = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDR_DIV  = 2'd0,
    IDR_DIVU = 2'd1,
    IDR_REM  = 2'd2,
    IDR_REMU = 2'd3
  } IDR_OP_TYPE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } IDR_STATE_TYPE;

endpackage

// File: rtl/idr_div_step.sv
// One combinational restoring-division step on magnitudes; no state, no backpressure.
module idr_div_step
  import idr_fu_pkg::*;
(
  input  logic [RSZ-1:0] rem,
  input  logic           dvd_msb,
  input  logic [RSZ-1:0] dvs,
  output logic [RSZ-1:0] rem_next,
  output logic           q_bit
);

  logic [RSZ:0] shifted;
  logic [RSZ:0] diff;

  // The partial remainder stays below dvs, so after the shift it needs one extra bit;
  // the borrow out of the RSZ+1-bit subtract is the inverted quotient bit.
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {1'b0, dvs};
    q_bit    = ~diff[RSZ];
    rem_next = q_bit ? diff[RSZ-1:0] : shifted[RSZ-1:0];
  end

endmodule

// File: rtl/idr_fu.sv
// RV32M DIV/DIVU/REM/REMU unit: 32 iterations plus one done cycle (special cases finish in 1).
// Requests are taken only in IDLE; the pipeline must stall while busy is high.
module idr_fu
  import idr_fu_pkg::*;
(
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           start,
  input  logic           flush,
  input  logic [1:0]     op,
  input  logic [RSZ-1:0] Rs1_data,
  input  logic [RSZ-1:0] Rs2_data,
  output logic           busy,
  output logic           done,
  output logic [RSZ-1:0] Rd_data
);

  IDR_STATE_TYPE  state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]     op_q;
  logic           s1, s2;
  logic [RSZ-1:0] rem, dvd, dvs;

  logic           is_signed, is_rem, in_s1, in_s2, dvs_zero, ovf;
  logic [RSZ-1:0] special_res, rem_next, q_final, calc_res;
  logic           q_bit;

  always_comb begin
    is_signed = ~op[0];
    is_rem    = op[1];
    in_s1     = is_signed & Rs1_data[RSZ-1];
    in_s2     = is_signed & Rs2_data[RSZ-1];
    dvs_zero  = (Rs2_data == '0);
    ovf       = is_signed && (Rs1_data == {1'b1, {(RSZ-1){1'b0}}}) && (Rs2_data == '1);
    // Signed overflow quotient equals the dividend itself (0x80000000).
    if (dvs_zero)
      special_res = is_rem ? Rs1_data : '1;
    else
      special_res = is_rem ? '0 : Rs1_data;
  end

  idr_div_step u_step (
    .rem      (rem),
    .dvd_msb  (dvd[RSZ-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    q_final = {dvd[RSZ-2:0], q_bit};
    case (op_q)
      IDR_DIV:  calc_res = (s1 ^ s2) ? -q_final : q_final;
      IDR_DIVU: calc_res = q_final;
      IDR_REM:  calc_res = s1 ? -rem_next : rem_next;
      default:  calc_res = rem_next;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      Rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q <= op;
            s1   <= in_s1;
            s2   <= in_s2;
            if (dvs_zero || ovf) begin
              Rd_data <= special_res;
              state   <= DONE;
            end else begin
              dvd   <= in_s1 ? -Rs1_data : Rs1_data;
              dvs   <= in_s2 ? -Rs2_data : Rs2_data;
              rem   <= '0;
              cnt   <= CNT_W'(RSZ - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            // Quotient bits fill the dividend register from the bottom as it shifts out.
            rem <= rem_next;
            dvd <= {dvd[RSZ-2:0], q_bit};
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              Rd_data <= calc_res;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idr_fu.sv
// Self-checking bench for idr_fu: directed RV32M corner cases plus randomized ops vs a reference model.
module tb_idr_fu;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] Rs1_data = '0;
  logic [31:0] Rs2_data = '0;
  logic        busy, done;
  logic [31:0] Rd_data;

  int          errs = 0;
  int          checks = 0;
  logic [31:0] last_rd = '0;

  idr_fu dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .Rs1_data (Rs1_data),
    .Rs2_data (Rs2_data),
    .busy     (busy),
    .done     (done),
    .Rd_data  (Rd_data)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics computed directly with language arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int  sa, sb;
    bit  ov;
    sa = a;
    sb = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return sa / sb;
      end
      2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op in cycle 0 and track done latency, busy coverage and the result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int          n;
    int          lat;
    bit          busy_ok;
    logic [31:0] exp_v;
    exp_v    = ref_result(o, a, b);
    lat      = is_special(o, a, b) ? 1 : 33;
    op       = o;
    Rs1_data = a;
    Rs2_data = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    n        = 1;
    busy_ok  = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      n++;
    end
    if (!busy) busy_ok = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " result"}, Rd_data, exp_v);
    chk({tag, " busy"}, 32'(busy_ok), 32'd1);
    tick();
    chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
    last_rd = exp_v;
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    int          n;
    bit          saw_done;

    tick();
    tick();
    chk("reset outputs", {30'd0, busy, done}, 32'd0);
    chk("reset rd", Rd_data, 32'd0);
    reset_in = 1'b1;
    tick();

    run_op(2'd1, 32'd100, 32'd7, "divu 100/7");
    run_op(2'd3, 32'd100, 32'd7, "remu 100/7");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "rem 7/-2");
    run_op(2'd0, 32'd5, 32'd0, "div 5/0");
    run_op(2'd3, 32'd5, 32'd0, "remu 5/0");
    run_op(2'd1, 32'd0, 32'd0, "divu 0/0");
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, "divu big");

    // Start while busy must not recapture operands.
    op = 2'd1; Rs1_data = 32'd1000; Rs2_data = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (n == 5) begin
        Rs1_data = 32'd9; Rs2_data = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("ignored start latency", 32'(n), 32'd33);
    chk("ignored start result", Rd_data, 32'd333);
    last_rd = 32'd333;
    tick();

    // Flush during CALC: back to idle, no done, result register untouched.
    op = 2'd1; Rs1_data = 32'd1000; Rs2_data = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c < 11; c++) begin
      if (done) saw_done = 1'b1;
      flush = (c == 10);
      tick();
    end
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush no done", {31'd0, done | saw_done}, 32'd0);
    chk("flush rd kept", Rd_data, last_rd);
    for (int c = 0; c < 40; c++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("flush no late done", {31'd0, saw_done}, 32'd0);

    // Start together with flush in IDLE is dropped.
    op = 2'd1; Rs1_data = 32'd9; Rs2_data = 32'd0; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start+flush busy", {31'd0, busy}, 32'd0);
    tick();
    chk("start+flush done", {31'd0, done}, 32'd0);
    chk("start+flush rd", Rd_data, last_rd);

    // Flush in DONE does not suppress the done pulse.
    op = 2'd0; Rs1_data = 32'd5; Rs2_data = 32'd0; start = 1'b1;
    tick();
    start = 1'b0; flush = 1'b1;
    chk("flush in done pulse", {31'd0, done}, 32'd1);
    chk("flush in done rd", Rd_data, 32'hFFFF_FFFF);
    tick();
    flush = 1'b0;
    chk("flush in done idle", {30'd0, busy, done}, 32'd0);
    last_rd = 32'hFFFF_FFFF;

    // Asynchronous reset in the middle of a signed divide.
    op = 2'd0; Rs1_data = 32'd1000; Rs2_data = 32'hFFFF_FFF9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    reset_in = 1'b0;
    #1;
    chk("mid reset outputs", {30'd0, busy, done}, 32'd0);
    chk("mid reset rd", Rd_data, 32'd0);
    tick();
    reset_in = 1'b1;
    tick();
    run_op(2'd1, 32'd9, 32'd3, "divu 9/3 after reset");

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'($urandom_range(0, 100));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(o, a, b, $sformatf("rnd%0d op%0d %h/%h", i, o, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
